// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner: time-multiplexed driver for a row of common-anode
// seven-segment digits. Digits, decimal points and blank masks are captured
// into a shadow register on a load strobe. Each digit gets one slot of CLK_DIV
// cycles, and the first BLANK_CYC cycles of every slot are dark to stop
// ghosting. Leading-zero suppression is applied from the live lz_en input.
//
// Optional build macro: SEVEN_SEG_HEX_AF_EN
//   defined   -> nibbles A..F decode to the letters A b C d E F
//   undefined -> nibbles A..F decode to a dash (segment g only)
module seven_seg_scanner #(
    parameter int NUM_DIGITS       = 4,
    parameter int CLK_DIV          = 50000,
    parameter int BLANK_CYC        = 2,
    parameter int ANODE_ACTIVE_LOW = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [4*NUM_DIGITS-1:0]   digits_in,
    input  logic [NUM_DIGITS-1:0]     dp_in,
    input  logic [NUM_DIGITS-1:0]     blank_in,
    input  logic                      lz_en,
    input  logic                      load,
    output logic [7:0]                seg_out,
    output logic [NUM_DIGITS-1:0]     an_out,
    output logic                      frame_done
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LIM = CNT_W'(BLANK_CYC);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

    // All anodes switched off, in board polarity.
    localparam logic [NUM_DIGITS-1:0] AN_OFF =
        (ANODE_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

    localparam logic [7:0] SEG_DARK = 8'hFF;

    // Nibble to active-low segments g..a (the DP bit is added separately).
    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'h40;
            4'h1:    s = 7'h79;
            4'h2:    s = 7'h24;
            4'h3:    s = 7'h30;
            4'h4:    s = 7'h19;
            4'h5:    s = 7'h12;
            4'h6:    s = 7'h02;
            4'h7:    s = 7'h78;
            4'h8:    s = 7'h00;
            4'h9:    s = 7'h18;
`ifdef SEVEN_SEG_HEX_AF_EN
            4'hA:    s = 7'h08;
            4'hB:    s = 7'h03;
            4'hC:    s = 7'h46;
            4'hD:    s = 7'h21;
            4'hE:    s = 7'h06;
            4'hF:    s = 7'h0E;
`endif
            default: s = 7'h3F;
        endcase
        return s;
    endfunction

    // State
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] dig_q, dig_d;
    logic [NUM_DIGITS-1:0]   dp_q, dp_d;
    logic [NUM_DIGITS-1:0]   blank_q, blank_d;
    logic [7:0]              seg_q, seg_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic                    frame_done_q, frame_done_d;

    // Combinational helpers
    logic [NUM_DIGITS-1:0]   supp_s;
    logic [NUM_DIGITS-1:0]   onehot_s;
    logic [3:0]              cur_nib_s;
    logic                    cur_dp_s;
    logic                    cur_dark_s;
    logic                    above_zero_s;

    // Shadow capture: the display only ever reads the shadow copy.
    always_comb begin
        if (load) begin
            dig_d   = digits_in;
            dp_d    = dp_in;
            blank_d = blank_in;
        end else begin
            dig_d   = dig_q;
            dp_d    = dp_q;
            blank_d = blank_q;
        end
    end

    // Slot counter and digit index; flag the wrap from the last digit to digit 0.
    always_comb begin
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        frame_done_d = 1'b0;
        if (cnt_q == CNT_LAST) begin
            cnt_d = {CNT_W{1'b0}};
            if (idx_q == IDX_LAST) begin
                idx_d        = {IDX_W{1'b0}};
                frame_done_d = 1'b1;
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Leading-zero mask: walk down from the top digit while everything above is
    // zero or blanked. Digit 0 and digits showing a DP are always kept.
    always_comb begin
        supp_s       = {NUM_DIGITS{1'b0}};
        above_zero_s = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            if ((k != 0) && lz_en && above_zero_s &&
                (dig_q[4*k +: 4] == 4'h0) && !dp_q[k]) begin
                supp_s[k] = 1'b1;
            end else begin
                supp_s[k] = 1'b0;
            end
            above_zero_s = above_zero_s &&
                           ((dig_q[4*k +: 4] == 4'h0) || blank_q[k]);
        end
    end

    // Select the nibble, DP and darkness of the digit under the scan index.
    always_comb begin
        cur_nib_s  = 4'h0;
        cur_dp_s   = 1'b0;
        cur_dark_s = 1'b0;
        onehot_s   = {NUM_DIGITS{1'b0}};
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx_q == IDX_W'(k)) begin
                cur_nib_s   = dig_q[4*k +: 4];
                cur_dp_s    = dp_q[k];
                cur_dark_s  = blank_q[k] | supp_s[k];
                onehot_s[k] = 1'b1;
            end else begin
                onehot_s[k] = 1'b0;
            end
        end
    end

    // Next segment/anode pattern: dark during the anti-ghost interval or for a
    // darkened digit, otherwise the decoded digit on its own anode.
    always_comb begin
        seg_d = SEG_DARK;
        an_d  = AN_OFF;
        if ((cnt_q < BLANK_LIM) || cur_dark_s) begin
            seg_d = SEG_DARK;
            an_d  = AN_OFF;
        end else begin
            seg_d = {~cur_dp_s, seg_decode(cur_nib_s)};
            if (ANODE_ACTIVE_LOW != 0) begin
                an_d = ~onehot_s;
            end else begin
                an_d = onehot_s;
            end
        end
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q        <= {CNT_W{1'b0}};
            idx_q        <= {IDX_W{1'b0}};
            dig_q        <= {(4*NUM_DIGITS){1'b0}};
            dp_q         <= {NUM_DIGITS{1'b0}};
            blank_q      <= {NUM_DIGITS{1'b0}};
            seg_q        <= SEG_DARK;
            an_q         <= AN_OFF;
            frame_done_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            dig_q        <= dig_d;
            dp_q         <= dp_d;
            blank_q      <= blank_d;
            seg_q        <= seg_d;
            an_q         <= an_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign seg_out    = seg_q;
    assign an_out     = an_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed bench for seven_seg_scanner with NUM_DIGITS=4, CLK_DIV=8,
// BLANK_CYC=2, ANODE_ACTIVE_LOW=1. Time index t counts rising edges since
// reset release; outputs are sampled on the falling edge. After edge t the
// outputs reflect scan position c = t-1: slot (c/8)%4, count c%8.
module tb_seven_seg_scanner;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] digits_in;
    logic [3:0]  dp_in;
    logic [3:0]  blank_in;
    logic        lz_en;
    logic        load;
    logic [7:0]  seg_out;
    logic [3:0]  an_out;
    logic        frame_done;

    int n_total = 0;
    int n_bad   = 0;
    int t       = 0;

    seven_seg_scanner #(
        .NUM_DIGITS       (4),
        .CLK_DIV          (8),
        .BLANK_CYC        (2),
        .ANODE_ACTIVE_LOW (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .digits_in  (digits_in),
        .dp_in      (dp_in),
        .blank_in   (blank_in),
        .lz_en      (lz_en),
        .load       (load),
        .seg_out    (seg_out),
        .an_out     (an_out),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        n_total = n_total + 1;
        if (obs !== exp_v) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %h expected %h (t=%0d)", tag, obs, exp_v, t);
        end
    endtask

    task automatic adv_to(input int target);
        while (t < target) begin
            @(negedge clk);
            t = t + 1;
        end
    endtask

    task automatic check_at(input int when, input string tag, input logic [3:0] an_e, input logic [7:0] seg_e);
        adv_to(when);
        check_val({tag, "_an"},  {12'h000, an_out},  {12'h000, an_e});
        check_val({tag, "_seg"}, {8'h00, seg_out},   {8'h00, seg_e});
    endtask

    // Present a new word with a one-cycle load strobe, starting at the current negedge.
    task automatic do_load(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] bl);
        digits_in = d;
        dp_in     = dp;
        blank_in  = bl;
        load      = 1'b1;
        adv_to(t + 1);
        load      = 1'b0;
    endtask

    logic [7:0] seg_hex_a;
    int pulses;
    int first_fd;
    int second_fd;

    initial begin
`ifdef SEVEN_SEG_HEX_AF_EN
        seg_hex_a = 8'h88;
`else
        seg_hex_a = 8'hBF;
`endif
        rst       = 1'b1;
        digits_in = 16'h0000;
        dp_in     = 4'b0000;
        blank_in  = 4'b0000;
        lz_en     = 1'b0;
        load      = 1'b0;
        pulses    = 0;
        first_fd  = 0;
        second_fd = 0;

        // 1. reset values, then frame_done every 32 cycles
        #1;
        check_val("rst_seg", {8'h00, seg_out}, 16'h00FF);
        check_val("rst_an",  {12'h000, an_out}, 16'h000F);
        check_val("rst_fd",  {15'h0000, frame_done}, 16'h0000);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        t   = 0;
        while (t < 64) begin
            @(negedge clk);
            t = t + 1;
            if (frame_done) begin
                if (pulses == 0) begin
                    first_fd = t;
                end else if (pulses == 1) begin
                    second_fd = t;
                end
                pulses = pulses + 1;
            end
            if (t == 1) begin
                check_val("t1_an",  {12'h000, an_out}, 16'h000F);
                check_val("t1_seg", {8'h00, seg_out},  16'h00FF);
            end
            if (t == 3) begin
                check_val("t3_an",  {12'h000, an_out}, 16'h000E);
                check_val("t3_seg", {8'h00, seg_out},  16'h00C0);
            end
        end
        check_val("fd_count",  16'(pulses),    16'd2);
        check_val("fd_first",  16'(first_fd),  16'd32);
        check_val("fd_second", 16'(second_fd), 16'd64);

        // 2. 1234 in frame starting at t=96
        adv_to(66);
        do_load(16'h1234, 4'b0000, 4'b0000);
        check_at(96,  "s2_prev_slot3", 4'b0111, 8'hF9);
        check_at(97,  "s2_blank_a",    4'b1111, 8'hFF);
        check_at(98,  "s2_blank_b",    4'b1111, 8'hFF);
        check_at(99,  "s2_d0_first",   4'b1110, 8'h99);
        check_at(104, "s2_d0_last",    4'b1110, 8'h99);
        check_at(107, "s2_d1",         4'b1101, 8'hB0);
        check_at(115, "s2_d2",         4'b1011, 8'hA4);
        check_at(123, "s2_d3",         4'b0111, 8'hF9);

        // 3. leading-zero suppression of 0050, then DP on digit 2
        adv_to(126);
        lz_en = 1'b1;
        do_load(16'h0050, 4'b0000, 4'b0000);
        check_at(131, "s3_d0", 4'b1110, 8'hC0);
        check_at(139, "s3_d1", 4'b1101, 8'h92);
        check_at(147, "s3_d2", 4'b1111, 8'hFF);
        check_at(155, "s3_d3", 4'b1111, 8'hFF);
        adv_to(158);
        do_load(16'h0050, 4'b0100, 4'b0000);
        check_at(163, "s3dp_d0", 4'b1110, 8'hC0);
        check_at(171, "s3dp_d1", 4'b1101, 8'h92);
        check_at(179, "s3dp_d2", 4'b1011, 8'h40);
        check_at(187, "s3dp_d3", 4'b1111, 8'hFF);

        // 4. hex digit A, then blanked top digit counting as zero for suppression
        adv_to(190);
        do_load(16'h000A, 4'b0000, 4'b0000);
        check_at(195, "s4_d0", 4'b1110, seg_hex_a);
        check_at(203, "s4_d1", 4'b1111, 8'hFF);
        adv_to(222);
        do_load(16'h7008, 4'b0000, 4'b1000);
        check_at(227, "s4b_d0", 4'b1110, 8'h80);
        check_at(235, "s4b_d1", 4'b1111, 8'hFF);
        check_at(243, "s4b_d2", 4'b1111, 8'hFF);
        check_at(251, "s4b_d3", 4'b1111, 8'hFF);

        // 5. mid-slot load: shadow written at edge 261, visible after edge 262
        adv_to(254);
        lz_en = 1'b0;
        do_load(16'h0000, 4'b0000, 4'b0000);
        check_at(260, "s5_before", 4'b1110, 8'hC0);
        do_load(16'h9999, 4'b0000, 4'b0000);
        check_val("s5_load_edge", {8'h00, seg_out}, 16'h00C0);
        check_at(262, "s5_after",     4'b1110, 8'h98);
        check_at(264, "s5_slot_end",  4'b1110, 8'h98);
        check_at(265, "s5_next_blank", 4'b1111, 8'hFF);
        check_at(267, "s5_d1",        4'b1101, 8'h98);
        adv_to(288);
        check_val("s5_fd", {15'h0000, frame_done}, 16'h0001);

        // 6. asynchronous reset in the middle of slot 2
        check_at(307, "s6_pre", 4'b1011, 8'h98);
        #2;
        rst = 1'b1;
        #1;
        check_val("s6_async_seg", {8'h00, seg_out}, 16'h00FF);
        check_val("s6_async_an",  {12'h000, an_out}, 16'h000F);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        t   = 0;
        check_at(2,  "s6_blank", 4'b1111, 8'hFF);
        check_at(3,  "s6_d0", 4'b1110, 8'hC0);
        check_at(11, "s6_d1", 4'b1101, 8'hC0);
        check_at(19, "s6_d2", 4'b1011, 8'hC0);
        check_at(27, "s6_d3", 4'b0111, 8'hC0);
        adv_to(31);
        check_val("s6_fd_low", {15'h0000, frame_done}, 16'h0000);
        adv_to(32);
        check_val("s6_fd", {15'h0000, frame_done}, 16'h0001);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/seven_seg_scanner.md
Name: seven_seg_scanner

Overview:
Time-multiplexed driver for a row of common-anode seven-segment digits.
- Accepts a packed BCD/hex word plus per-digit decimal-point and blank masks, and captures them into a shadow register on a load strobe.
- Scans one digit per slot, with an anti-ghosting blank interval at the start of each slot.
- Sits between the stopwatch/counter datapath and the board's segment/anode pins, and generalises the single-digit decoder to N digits.

Parameters:
- NUM_DIGITS, 4: number of digits scanned (1..8).
- CLK_DIV, 50000: clk cycles per digit slot (>= 4).
- BLANK_CYC, 2: cycles at the start of each slot with all anodes off (1..CLK_DIV-2).
- ANODE_ACTIVE_LOW, 1: 1 drives anodes low when active; 0 drives them high when active.

Ports:
- clk, in, 1: system clock; all state is on the rising edge.
- rst, in, 1: asynchronous, active-high reset.
- digits_in, in, 4*NUM_DIGITS: nibble k = digit k; digit 0 is the least significant and rightmost.
- dp_in, in, NUM_DIGITS: 1 lights the decimal point of digit k.
- blank_in, in, NUM_DIGITS: 1 forces digit k dark.
- lz_en, in, 1: leading-zero suppression enable; sampled live, not shadowed.
- load, in, 1: 1-cycle strobe that captures digits_in, dp_in and blank_in into the shadow register.
- seg_out, out, 8: active-low segments; bit 7 = DP, bits 6:0 = g..a.
- an_out, out, NUM_DIGITS: anode enables, polarity set by ANODE_ACTIVE_LOW.
- frame_done, out, 1: 1-cycle pulse when the scan wraps from the last digit to digit 0.

Behaviour:
- Reset (async, immediate):
  - slot counter = 0, digit index = 0, shadow registers = 0.
  - seg_out = 8'hFF, an_out = all inactive, frame_done = 0.
- Shadow capture: load=1 at an edge writes the shadow at that edge; the display uses the shadow only, never the live inputs.
- Slot counter:
  - Counts 0..CLK_DIV-1.
  - At CLK_DIV-1 it wraps to 0 and the index increments.
  - The index wraps NUM_DIGITS-1 -> 0; frame_done = 1 on the cycle after that wrap.
  - Frame period = NUM_DIGITS*CLK_DIV cycles.
- Outputs are registered, with 1-cycle latency from (counter, index, shadow, lz_en).
  - Blank interval: counter < BLANK_CYC -> an all inactive, seg 8'hFF.
  - Otherwise the anode of the current index is active and all others inactive.
  - seg = decode(nibble), with bit 7 = ~dp.
- Darkened digit: a digit is dark if its blank bit is set, or if it is leading-zero-suppressed. A dark digit drives its anode inactive and seg 8'hFF.
- Leading-zero suppression (lz_en=1): digit k is suppressed if its nibble is 0 and every digit above k is 0 or blanked. Digit 0 is never suppressed. A digit with its dp set is never suppressed.
- Decode, digits 0-9 (active-low):
  - 0 = C0, 1 = F9, 2 = A4, 3 = B0, 4 = 99
  - 5 = 92, 6 = 82, 7 = F8, 8 = 80, 9 = 98
- Decode, values A-F: per the optional feature below.
- load during an active slot: the new value appears on seg_out 2 edges after the load edge, mid-slot. No scan restart.
- load held high: the shadow updates every cycle.
- Reset mid-frame: counter, index and shadow are cleared; scanning resumes at digit 0 on release.

Optional Feature:
Macro: SEVEN_SEG_HEX_AF_EN
- Defined: A-F decode to letters, with DP off:
  - A = 88, b = 83, C = C6
  - d = A1, E = 86, F = 8E
- Undefined: A-F decode to a dash, BF (segment g only).

Test Plan:
All scenarios use NUM_DIGITS=4, CLK_DIV=8, BLANK_CYC=2, ANODE_ACTIVE_LOW=1.

1. Assert rst, then release:
   - seg_out = FF and an_out = 1111 immediately.
   - frame_done pulses every 32 cycles.
2. load with digits_in=16'h1234, dp=0, blank=0:
   - Slot 0: an = 1110, seg = 99.
   - Slot 3: an = 0111, seg = F9.
   - First 2 cycles of each slot (plus 1 cycle of latency): an = 1111, seg = FF.
3. lz_en=1, load digits_in=16'h0050:
   - Digits 3 and 2 dark (an bits stay 1).
   - Digit 1: seg = 92. Digit 0: seg = C0.
   - Set dp_in=4'b0100 and load: digit 2 becomes active with seg = 40.
4. Load digits_in=16'h000A:
   - Without SEVEN_SEG_HEX_AF_EN: digit 0 seg = BF.
   - With SEVEN_SEG_HEX_AF_EN: digit 0 seg = 88.
5. Pulse load with 16'h9999 mid-slot 0 while 16'h0000 is displayed:
   - seg changes C0 -> 98 exactly 2 edges after the load edge.
   - an_out and slot timing are unchanged.
6. Assert rst mid-slot 2:
   - Outputs go to FF/1111 asynchronously.
   - After release with no load, all digits show C0 (lz_en=0).
